// File: rtl/jk_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// jk_pkg : FSM state type and per-bit JK excitation helper.   Rev 1.0
// ----------------------------------------------------------------------------
package jk_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4,
    FAIL   = 3'd5
  } jk_state_t;

  // Returns {j,k} that moves a JK flop from q to t; dc fills the don't-care.
  function automatic logic [1:0] jk_excite(input logic q, input logic t, input logic dc);
    return q ? {dc, ~t} : {t, dc};
  endfunction

endpackage
`default_nettype wire

// File: rtl/jk_excite_bank.sv
`default_nettype none
// ----------------------------------------------------------------------------
// jk_excite_bank : WIDTH-wide combinational JK excitation.     Rev 1.0
// ----------------------------------------------------------------------------
module jk_excite_bank
  import jk_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int DC_VAL = 0
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] t_i,
  output logic [WIDTH-1:0] j_o,
  output logic [WIDTH-1:0] k_o
);

  localparam logic DC = (DC_VAL != 0);

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    logic [1:0] w_jk;
    assign w_jk   = jk_excite(q_i[b], t_i[b], DC);
    assign j_o[b] = w_jk[1];
    assign k_o[b] = w_jk[0];
  end

endmodule
`default_nettype wire

// File: rtl/jk_bank_driver.sv
`default_nettype none
// ----------------------------------------------------------------------------
// jk_bank_driver : drives a JK bank toward a target word, checks, retries.  Rev 1.0
// ----------------------------------------------------------------------------
module jk_bank_driver
  import jk_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int DC_VAL    = 0,
  parameter int MAX_RETRY = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             tgt_valid_i,
  output logic             tgt_ready_o,
  input  logic [WIDTH-1:0] tgt_i,
  input  logic [WIDTH-1:0] q_fb_i,
  output logic [WIDTH-1:0] j_o,
  output logic [WIDTH-1:0] k_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  jk_state_t        state_q;
  logic [RW-1:0]    retry_q;
  logic [RW-1:0]    retry_d;
  logic [WIDTH-1:0] tgt_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  logic             w_drive;

  assign retry_d = retry_q + RW'(1);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      retry_q <= '0;
      tgt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (tgt_valid_i) begin
            tgt_q   <= tgt_i;
            retry_q <= '0;
            busy_q  <= 1'b1;
            state_q <= DRIVE;
          end
        end
        DRIVE:  state_q <= SETTLE;
        SETTLE: state_q <= CHECK;
        CHECK: begin
          if (q_fb_i == tgt_q) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (32'(retry_q) < MAX_RETRY) begin
            // Only advanced below MAX_RETRY, so the counter never wraps.
            retry_q <= retry_d;
            state_q <= DRIVE;
          end else begin
            err_q   <= 1'b1;
            state_q <= FAIL;
          end
        end
        DONE, FAIL: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  jk_excite_bank #(
    .WIDTH  (WIDTH),
    .DC_VAL (DC_VAL)
  ) u_excite (
    .q_i (q_fb_i),
    .t_i (tgt_q),
    .j_o (w_j),
    .k_o (w_k)
  );

  // Outside DRIVE the bank must hold, so J/K are forced low.
  assign w_drive     = (state_q == DRIVE);
  assign j_o         = w_drive ? w_j : '0;
  assign k_o         = w_drive ? w_k : '0;
  assign tgt_ready_o = rst_i && (state_q == IDLE);
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_jk_bank_driver.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_jk_bank_driver : self-checking bench, DC_VAL=0 and DC_VAL=1 instances.  Rev 1.0
// ----------------------------------------------------------------------------
module tb_jk_bank_driver;

  localparam int W    = 4;
  localparam int MR   = 2;
  localparam int NCYC = 3 * (MR + 1) + 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         tgt_valid;
  logic [W-1:0] tgt;
  logic [W-1:0] bank0, bank1, stuck, load_val;
  logic         load_en;
  logic [W-1:0] j0, k0, j1, k1;
  logic         rdy0, busy0, done0, err0;
  logic         rdy1, busy1, done1, err1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] rj0 [16];
  logic [W-1:0] rk0 [16];
  logic [W-1:0] rj1 [16];
  logic [W-1:0] rk1 [16];
  logic [W-1:0] rq  [16];
  logic [7:0]   rfl [16];

  always #5 clk = ~clk;

  jk_bank_driver #(.WIDTH(W), .DC_VAL(0), .MAX_RETRY(MR)) dut0 (
    .clk_i(clk), .rst_i(rst_n), .tgt_valid_i(tgt_valid), .tgt_ready_o(rdy0),
    .tgt_i(tgt), .q_fb_i(bank0), .j_o(j0), .k_o(k0),
    .busy_o(busy0), .done_o(done0), .err_o(err0)
  );

  jk_bank_driver #(.WIDTH(W), .DC_VAL(1), .MAX_RETRY(MR)) dut1 (
    .clk_i(clk), .rst_i(rst_n), .tgt_valid_i(tgt_valid), .tgt_ready_o(rdy1),
    .tgt_i(tgt), .q_fb_i(bank1), .j_o(j1), .k_o(k1),
    .busy_o(busy1), .done_o(done1), .err_o(err1)
  );

  // Behavioural JK banks; bits set in 'stuck' are stuck at 0.
  always @(posedge clk) begin
    if (load_en) begin
      bank0 <= load_val & ~stuck;
      bank1 <= load_val & ~stuck;
    end else begin
      bank0 <= ((j0 & ~bank0) | (~k0 & bank0)) & ~stuck;
      bank1 <= ((j1 & ~bank1) | (~k1 & bank1)) & ~stuck;
    end
  end

  task automatic capture(input int n, input bit hold);
    for (int c = 1; c <= n; c++) begin
      @(posedge clk); #1;
      if (!hold && c == 1) tgt_valid = 1'b0;
      rj0[c] = j0; rk0[c] = k0; rj1[c] = j1; rk1[c] = k1; rq[c] = bank0;
      rfl[c] = {done0, err0, busy0, rdy0, done1, err1, busy1, rdy1};
    end
  endtask

  task automatic load_bank(input logic [W-1:0] v, input logic [W-1:0] stk);
    stuck = stk; load_val = v; load_en = 1'b1;
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  task automatic test_reset();
    logic [23:0] obs;
    rst_n = 1'b0; tgt_valid = 1'b1; tgt = 4'hA;
    stuck = '0; load_val = '0; load_en = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      load_en = 1'b0;
      tgt = W'($urandom);
      obs = {j0, k0, j1, k1, done0, err0, busy0, rdy0, done1, err1, busy1, rdy1};
      n_tests++;
      if (obs !== 24'h0) begin
        n_fail++;
        $display("FAIL reset_hold cyc %0d: got %h expected %h", c, obs, 24'h0);
      end
    end
    rst_n = 1'b1; tgt_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      obs = {j0, k0, j1, k1, done0, err0, busy0, rdy0, done1, err1, busy1, rdy1};
      n_tests++;
      if (obs !== 24'h000011) begin
        n_fail++;
        $display("FAIL reset_release cyc %0d: got %h expected %h", c, obs, 24'h000011);
      end
    end
  endtask

  // One full transaction; expectations come from JK semantics, not the FSM.
  task automatic test_excite(input string name, input logic [W-1:0] start,
                             input logic [W-1:0] t, input logic [W-1:0] stk);
    logic [W-1:0] q0, fin, qm, ej0, ek0, ej1, ek1;
    logic [23:0]  obs, exp;
    bit ok, isdrv, ed, ee, eb, er;
    int ndrv, endc, di;
    load_bank(start, stk);
    tgt = t; tgt_valid = 1'b1;
    capture(NCYC, 1'b0);
    q0   = start & ~stk;
    fin  = t & ~stk;
    ok   = (fin == t);
    ndrv = ok ? 1 : MR + 1;
    endc = 3 * ndrv + 1;
    for (int c = 1; c <= NCYC; c++) begin
      di    = (c - 1) / 3;
      isdrv = ((c - 1) % 3 == 0) && (di < ndrv);
      qm    = (di == 0) ? q0 : fin;
      ej0 = isdrv ? (~qm & t)        : '0;
      ek0 = isdrv ? (qm & ~t)        : '0;
      ej1 = isdrv ? ((~qm & t) | qm) : '0;
      ek1 = isdrv ? ((qm & ~t) | ~qm): '0;
      ed = ok && (c == endc);
      ee = !ok && (c == endc);
      eb = (c <= endc);
      er = (c > endc);
      exp = {ej0, ek0, ej1, ek1, ed, ee, eb, er, ed, ee, eb, er};
      obs = {rj0[c], rk0[c], rj1[c], rk1[c], rfl[c]};
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL %s cyc %0d: got %h expected %h", name, c, obs, exp);
      end
    end
    n_tests++;
    if (rq[endc] !== fin) begin
      n_fail++;
      $display("FAIL %s bank: got %h expected %h", name, rq[endc], fin);
    end
  endtask

  task automatic test_abort();
    logic [23:0] obs;
    load_bank(4'b0101, '0);
    tgt = 4'b1010; tgt_valid = 1'b1;
    capture(2, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    obs = {j0, k0, j1, k1, done0, err0, busy0, rdy0, done1, err1, busy1, rdy1};
    n_tests++;
    if (obs !== 24'h0) begin
      n_fail++;
      $display("FAIL abort_reset: got %h expected %h", obs, 24'h0);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      obs = {j0, k0, j1, k1, done0, err0, busy0, rdy0, done1, err1, busy1, rdy1};
      n_tests++;
      if (obs !== 24'h000011) begin
        n_fail++;
        $display("FAIL abort_idle cyc %0d: got %h expected %h", c, obs, 24'h000011);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] s, a, b, ej, ek;
    logic [11:0]  obs, exp;
    bit ed, eb, er, dr;
    s = W'($urandom);
    a = W'($urandom);
    b = a ^ W'($urandom_range(1, 15));
    load_bank(s, '0);
    tgt = a; tgt_valid = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (c <= 3) tgt = W'($urandom);
      if (c == 4) tgt = b;
      if (c == 6) tgt_valid = 1'b0;
      rj0[c] = j0; rk0[c] = k0; rq[c] = bank0;
      rfl[c] = {done0, err0, busy0, rdy0, done1, err1, busy1, rdy1};
    end
    for (int c = 1; c <= 10; c++) begin
      dr = (c == 1) || (c == 6);
      ej = (c == 1) ? (~s & a) : (c == 6) ? (~a & b) : '0;
      ek = (c == 1) ? (s & ~a) : (c == 6) ? (a & ~b) : '0;
      if (!dr) begin ej = '0; ek = '0; end
      ed = (c == 4) || (c == 9);
      eb = (c <= 4) || (c >= 6 && c <= 9);
      er = (c == 5) || (c == 10);
      exp = {ej, ek, ed, 1'b0, eb, er};
      obs = {rj0[c], rk0[c], rfl[c][7:4]};
      n_tests++;
      if (obs !== exp || rfl[c][7:4] !== rfl[c][3:0]) begin
        n_fail++;
        $display("FAIL b2b cyc %0d: got %h/%h expected %h", c, obs, rfl[c][3:0], exp);
      end
    end
    n_tests++;
    if (rq[4] !== a || rq[9] !== b) begin
      n_fail++;
      $display("FAIL b2b_bank: got %h,%h expected %h,%h", rq[4], rq[9], a, b);
    end
  endtask

  initial begin
    logic [W-1:0] rs, rt, rk;
    test_reset();
    test_excite("dc_directed", 4'b0101, 4'b0011, 4'b0000);
    test_excite("stuck_retry", 4'b0000, 4'b0001, 4'b0001);
    test_abort();
    test_excite("after_abort", 4'b1100, 4'b0110, 4'b0000);
    test_back_to_back();
    for (int i = 0; i < 10; i++) begin
      rs = W'($urandom);
      rt = W'($urandom);
      rk = ($urandom_range(0, 2) == 0) ? W'($urandom) : '0;
      test_excite("random", rs, rt, rk);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
